// File: rtl/demux_1to2_stream_if.sv
// Stream bundle for the 1-to-2 demultiplexer: one producer port, two consumer channels.
// The master side drives producer data and consumer ready; the slave side is the demux.
interface demux_1to2_stream_if #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
);
    logic [DATA_W-1:0] in_data;
    logic              in_sel;
    logic              in_valid;
    logic              in_ready;

    logic [DATA_W-1:0] a_data;
    logic              a_valid;
    logic              a_ready;

    logic [DATA_W-1:0] b_data;
    logic              b_valid;
    logic              b_ready;

    logic [CNT_W-1:0]  a_cnt;
    logic [CNT_W-1:0]  b_cnt;

    modport master (
        output in_data, in_sel, in_valid, a_ready, b_ready,
        input  in_ready, a_data, a_valid, b_data, b_valid, a_cnt, b_cnt
    );

    modport slave (
        input  in_data, in_sel, in_valid, a_ready, b_ready,
        output in_ready, a_data, a_valid, b_data, b_valid, a_cnt, b_cnt
    );
endinterface

// File: rtl/demux_1to2_stream.sv
// Registered 1-to-2 stream demux: each word goes to channel A (sel=0) or B (sel=1),
// each channel a one-word register with valid/ready. Macro DEMUX_CNT_EN adds drain counters.
module demux_1to2_stream #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
) (
    input logic                 clk,
    input logic                 reset,
    demux_1to2_stream_if.slave  bus
);

    logic [DATA_W-1:0] a_data_q, a_data_d;
    logic [DATA_W-1:0] b_data_q, b_data_d;
    logic              a_valid_q, a_valid_d;
    logic              b_valid_q, b_valid_d;

    logic free_a, free_b;
    logic in_ready;
    logic load_a, load_b;
    logic drain_a, drain_b;

    // A channel is free when empty or when its word leaves this cycle, so a full
    // channel can refill on the same edge it drains.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        free_a    = !a_valid_q || bus.a_ready;
        free_b    = !b_valid_q || bus.b_ready;
        in_ready  = bus.in_sel ? free_b : free_a;
        load_a    = bus.in_valid && in_ready && !bus.in_sel;
        load_b    = bus.in_valid && in_ready &&  bus.in_sel;
        drain_a   = a_valid_q && bus.a_ready;
        drain_b   = b_valid_q && bus.b_ready;

        a_valid_d = a_valid_q;
        a_data_d  = a_data_q;
        b_valid_d = b_valid_q;
        b_data_d  = b_data_q;

        if (drain_a) a_valid_d = 1'b0;
        if (load_a) begin
            a_valid_d = 1'b1;
            a_data_d  = bus.in_data;
        end

        if (drain_b) b_valid_d = 1'b0;
        if (load_b) begin
            b_valid_d = 1'b1;
            b_data_d  = bus.in_data;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            a_valid_q <= 1'b0;
            b_valid_q <= 1'b0;
            a_data_q  <= '0;
            b_data_q  <= '0;
        end else begin
            a_valid_q <= a_valid_d;
            b_valid_q <= b_valid_d;
            a_data_q  <= a_data_d;
            b_data_q  <= b_data_d;
        end
    end

    assign bus.in_ready = in_ready;
    assign bus.a_data   = a_data_q;
    assign bus.a_valid  = a_valid_q;
    assign bus.b_data   = b_data_q;
    assign bus.b_valid  = b_valid_q;

`ifdef DEMUX_CNT_EN
    logic [CNT_W-1:0] a_cnt_q, a_cnt_d;
    logic [CNT_W-1:0] b_cnt_q, b_cnt_d;

    // Counters wrap naturally at all-ones.
    always_comb begin
        a_cnt_d = a_cnt_q;
        b_cnt_d = b_cnt_q;
        if (drain_a) a_cnt_d = a_cnt_q + 1'b1;
        if (drain_b) b_cnt_d = b_cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_cnt_q <= '0;
            b_cnt_q <= '0;
        end else begin
            a_cnt_q <= a_cnt_d;
            b_cnt_q <= b_cnt_d;
        end
    end

    assign bus.a_cnt = a_cnt_q;
    assign bus.b_cnt = b_cnt_q;
`else
    assign bus.a_cnt = '0;
    assign bus.b_cnt = '0;
`endif

endmodule

// File: tb/tb_demux_1to2_stream.sv
// Self-checking bench for demux_1to2_stream: directed scenarios then random traffic,
// compared against a queue-based model of two one-word channels.
module tb_demux_1to2_stream;

    localparam int DATA_W = 8;
    localparam int CNT_W  = 4;
    localparam int CNT_MOD = 1 << CNT_W;

    logic clk;
    logic reset;

    demux_1to2_stream_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

    demux_1to2_stream #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Model: each channel is a queue of capacity one plus its last loaded word.
    logic [DATA_W-1:0] a_q[$];
    logic [DATA_W-1:0] b_q[$];
    logic [DATA_W-1:0] a_last, b_last;
    int a_cnt_m, b_cnt_m;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int cnt_exp(input int m);
`ifdef DEMUX_CNT_EN
        return m;
`else
        return 0 * m;
`endif
    endfunction

    task automatic check_outputs(input string tag);
        check({tag, ".a_valid"}, 32'(bus.a_valid), 32'(a_q.size() != 0));
        check({tag, ".b_valid"}, 32'(bus.b_valid), 32'(b_q.size() != 0));
        check({tag, ".a_data"},  32'(bus.a_data),  32'(a_last));
        check({tag, ".b_data"},  32'(bus.b_data),  32'(b_last));
        check({tag, ".a_cnt"},   32'(bus.a_cnt),   32'(cnt_exp(a_cnt_m)));
        check({tag, ".b_cnt"},   32'(bus.b_cnt),   32'(cnt_exp(b_cnt_m)));
    endtask

    // One clock: drive inputs, check in_ready, advance model, check registered outputs.
    task automatic cycle(input string tag, input logic rst, input logic v, input logic s,
                         input logic [DATA_W-1:0] d, input logic ar, input logic br);
        logic exp_ready;
        reset        = rst;
        bus.in_valid = v;
        bus.in_sel   = s;
        bus.in_data  = d;
        bus.a_ready  = ar;
        bus.b_ready  = br;
        #1;
        exp_ready = s ? (b_q.size() == 0 || br) : (a_q.size() == 0 || ar);
        if (!rst) check({tag, ".in_ready"}, 32'(bus.in_ready), 32'(exp_ready));
        if (rst) begin
            a_q.delete();
            b_q.delete();
            a_last  = '0;
            b_last  = '0;
            a_cnt_m = 0;
            b_cnt_m = 0;
        end else begin
            if (a_q.size() != 0 && ar) begin
                void'(a_q.pop_front());
                a_cnt_m = (a_cnt_m + 1) % CNT_MOD;
            end
            if (b_q.size() != 0 && br) begin
                void'(b_q.pop_front());
                b_cnt_m = (b_cnt_m + 1) % CNT_MOD;
            end
            if (v && exp_ready) begin
                if (s) begin
                    b_q.push_back(d);
                    b_last = d;
                end else begin
                    a_q.push_back(d);
                    a_last = d;
                end
            end
        end
        @(posedge clk);
        #1;
        check_outputs(tag);
    endtask

    initial begin
        a_last = '0; b_last = '0; a_cnt_m = 0; b_cnt_m = 0;
        reset = 1'b1;
        bus.in_valid = 1'b0; bus.in_sel = 1'b0; bus.in_data = '0;
        bus.a_ready = 1'b0; bus.b_ready = 1'b0;

        // Reset for two cycles, then in_ready for both selects on an empty block.
        cycle("rst0", 1, 0, 0, 8'h00, 0, 0);
        cycle("rst1", 1, 0, 0, 8'h00, 0, 0);
        check("rst.a_data_zero", 32'(bus.a_data), 32'h0);
        cycle("idle_sel0", 0, 0, 0, 8'h00, 0, 0);
        cycle("idle_sel1", 0, 0, 1, 8'h00, 0, 0);

        // Single word to A, delivered and then gone.
        cycle("a5_load", 0, 1, 0, 8'hA5, 1, 1);
        check("a5_visible", 32'(bus.a_data), 32'hA5);
        cycle("a5_drain", 0, 0, 0, 8'h00, 1, 1);
        check("a5_gone", 32'(bus.a_valid), 32'h0);

        // A stalled with A5; A-bound word refused, B-bound word accepted.
        cycle("stall_load", 0, 1, 0, 8'hA5, 0, 0);
        cycle("stall_3c",   0, 1, 0, 8'h3C, 0, 0);
        check("stall_hold", 32'(bus.a_data), 32'hA5);
        cycle("bypass_5a",  0, 1, 1, 8'h5A, 0, 0);
        check("bypass_b",   32'(bus.b_data), 32'h5A);
        cycle("stall_flush", 0, 0, 0, 8'h00, 1, 1);

        // Back-to-back words on A at full throughput.
        for (int i = 1; i <= 4; i++) begin
            cycle("burst", 0, 1, 0, DATA_W'(i), 1, 0);
            check("burst_data", 32'(bus.a_data), 32'(i));
        end
        cycle("burst_end", 0, 0, 0, 8'h00, 1, 0);

        // Reset while A holds an undelivered word drops it.
        cycle("hold77", 0, 1, 0, 8'h77, 0, 0);
        cycle("rst_pulse", 1, 0, 0, 8'h00, 0, 0);
        check("drop77", 32'(bus.a_valid), 32'h0);
        cycle("after_rst", 0, 0, 0, 8'h00, 1, 1);

        // 17 deliveries on A wrap a 4-bit counter to 1.
        for (int i = 0; i < 17; i++) cycle("cnt17", 0, 1, 0, DATA_W'(i + 8'h10), 1, 0);
        cycle("cnt17_end", 0, 0, 0, 8'h00, 1, 0);
`ifdef DEMUX_CNT_EN
        check("cnt17_a", 32'(bus.a_cnt), 32'd1);
`else
        check("cnt17_a", 32'(bus.a_cnt), 32'd0);
`endif
        check("cnt17_b", 32'(bus.b_cnt), 32'd0);

        // Random traffic with random back-pressure.
        for (int i = 0; i < 400; i++) begin
            cycle("rand", 0, 1'($urandom), 1'($urandom), DATA_W'($urandom),
                  1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
